uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single uart_tx instance and its RS485 driver between several frame sources:
//  status replies, setpoint/control-mode ACKs, and future telemetry.
//  Grants the UART round-robin, then fetches and serialises the granted source's frame one
//  byte at a time. Enforces a bus-turnaround guard after each frame and a per-byte watchdog
//  on tx_done. Sits between the comms frame logic and uart_tx.
// PARAMETERS
//  NUM_REQ        2    number of requesters (2..8)
//  GUARD_CYCLES   16   idle CLK cycles after a frame before any new grant (>=1)
//  TIMEOUT_CYCLES 4096 max CLK cycles from tx_transmit to tx_done before abort
// PORTS
//  CLK          in   1          system clock
//  reset_n      in   1          reset, asynchronous, active-low
//  req          in   NUM_REQ    level request per source; held until its done/err pulse
//  req_len      in   NUM_REQ*8  frame length in bytes per source, slice i = [8i+7:8i]
//  byte_data    in   NUM_REQ*8  byte at byte_idx from each source, combinational in source
//  grant        out  NUM_REQ    one-hot owner of the UART, 0 when free
//  byte_idx     out  8          index of byte requested from the granted source
//  done         out  NUM_REQ    1-cycle pulse: frame fully sent
//  err          out  NUM_REQ    1-cycle pulse: frame aborted (req dropped or timeout)
//  tx_transmit  out  1          1-cycle start strobe to uart_tx
//  tx_data      out  8          byte to uart_tx, stable from strobe until tx_done
//  tx_active    in   1          uart_tx busy
//  tx_done      in   1          uart_tx 1-cycle byte-complete pulse
//  busy         out  1          high in any state except IDLE
// BEHAVIOUR
//  Reset: grant=0, byte_idx=0, done=0, err=0, tx_transmit=0, tx_data=0, busy=0.
//   RR pointer=0; state=IDLE. A reset mid-frame drops tx_transmit at once and emits no done/err.
//  FSM: IDLE -> FETCH -> SEND -> WAIT -> (FETCH | GUARD) -> IDLE.
//  IDLE: if any req, pick the first set bit searching from the RR pointer upward, with wrap.
//   Next cycle: grant=one-hot(winner), byte_idx=0, latch len=req_len[winner].
//   If latched len==0: pulse done[winner], clear grant, go to GUARD (no bytes sent).
//  FETCH: one cycle. tx_data <= byte_data[winner][byte_idx]; go to SEND.
//  SEND: tx_transmit=1 for exactly this cycle, but only if tx_active==0; else stay in SEND.
//   Start the watchdog counter. Go to WAIT.
//  WAIT: on tx_done:
//   - byte_idx==len-1: next cycle pulse done[winner], grant=0, go to GUARD.
//   - otherwise: byte_idx++, go to FETCH.
//   Inter-byte gap is therefore 2 cycles after tx_done.
//  Abort (checked in FETCH/SEND/WAIT):
//   - req[winner] falls: finish the byte in flight (wait for tx_done), then pulse err[winner],
//     clear grant, go to GUARD.
//   - watchdog reaches TIMEOUT_CYCLES without tx_done: pulse err[winner], clear grant at once,
//     go to GUARD.
//  GUARD: count GUARD_CYCLES, then IDLE. req is ignored here; the RR pointer is set to
//   winner+1 mod NUM_REQ on entry.
//  done and err are mutually exclusive, and only ever pulse for the current winner.
//  byte_idx wraps never: len is <=255, so byte_idx<=254.
//  Simultaneous: when several req rise in the same cycle, the RR order decides.
//   A tx_done arriving in the same cycle as a req drop counts as byte complete, then abort.
//  byte_data and req_len of non-granted sources are don't-care. req_len changing after
//   the grant is ignored.
// TESTING
//  1. req=01, len0=3, bytes AA,BB,CC; uart model with tx_done 10 cycles after the strobe.
//     -> tx_data AA,BB,CC in order, 3 strobes, done[0] one cycle after the 3rd tx_done,
//        then 16 idle cycles.
//  2. req=11 in the same cycle after reset, both len=2.
//     -> src0 served first, then src1 after the guard; a second run serves src1 first
//        (RR pointer advanced).
//  3. req=10, len1=0.
//     -> no tx_transmit, done[1] pulses 1 cycle after grant, busy high for 1+16 cycles.
//  4. len0=4, drop req[0] during the 2nd byte.
//     -> 2nd byte completes, err[0] pulses, no 3rd strobe, no done[0].
//  5. uart model never asserts tx_done (TIMEOUT_CYCLES=64).
//     -> err pulses 64 cycles after the strobe, grant=0, IDLE again after the guard.
//  6. Assert reset_n=0 mid-WAIT.
//     -> all outputs 0 asynchronously; after release, a new req=01 is served from byte 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared uart_tx / RS485 driver.
// Serialises the granted source's frame byte by byte, then holds a bus-turnaround guard.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GUARD_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_len,
    input  logic [NUM_REQ*8-1:0] byte_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           byte_idx,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic                 tx_transmit,
    output logic [7:0]           tx_data,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic                 busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT,
        S_GUARD
    } state_t;

    state_t             r_state, w_state_nx;
    logic [NUM_REQ-1:0] r_grant, w_grant_nx;
    logic [IW-1:0]      r_win, w_win_nx;
    logic [IW-1:0]      r_ptr, w_ptr_nx;
    logic [7:0]         r_len, w_len_nx;
    logic [7:0]         r_idx, w_idx_nx;
    logic [7:0]         r_data, w_data_nx;
    logic [WW-1:0]      r_wdog, w_wdog_nx;
    logic [GW-1:0]      r_gcnt, w_gcnt_nx;
    logic               r_drop, w_drop_nx;
    logic [NUM_REQ-1:0] r_done, w_done_nx;
    logic [NUM_REQ-1:0] r_err, w_err_nx;

    logic               w_any, w_hhit, w_own, w_tx, w_end;
    logic [IW-1:0]      w_hi, w_lo, w_pick, w_nptr;
    logic [NUM_REQ-1:0] w_onehot;
    logic [7:0]         w_byte, w_plen;

    // Lowest request at or above the pointer wins, else the lowest overall.
    always_comb begin
        w_any    = |req;
        w_hhit   = 1'b0;
        w_hi     = '0;
        w_lo     = '0;
        w_onehot = '0;
        w_byte   = 8'h00;
        w_plen   = 8'h00;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j]) w_lo = IW'(j);
            if (req[j] && IW'(j) >= r_ptr) begin
                w_hi   = IW'(j);
                w_hhit = 1'b1;
            end
        end
        w_pick = w_hhit ? w_hi : w_lo;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_onehot[j] = (w_pick == IW'(j));
            if (w_pick == IW'(j)) w_plen = req_len[8*j +: 8];
            if (r_win == IW'(j))  w_byte = byte_data[8*j +: 8];
        end
        w_nptr = (r_win == IW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
        w_own  = |(req & r_grant);
    end

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_win_nx   = r_win;
        w_ptr_nx   = r_ptr;
        w_len_nx   = r_len;
        w_idx_nx   = r_idx;
        w_data_nx  = r_data;
        w_wdog_nx  = r_wdog;
        w_gcnt_nx  = r_gcnt;
        w_drop_nx  = r_drop;
        w_done_nx  = '0;
        w_err_nx   = '0;
        w_tx       = 1'b0;
        w_end      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_nx = w_onehot;
                    w_win_nx   = w_pick;
                    w_len_nx   = w_plen;
                    w_idx_nx   = 8'd0;
                    w_drop_nx  = 1'b0;
                    w_state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_len == 8'd0) begin
                    w_done_nx = r_grant;
                    w_end     = 1'b1;
                end else if (!w_own) begin
                    w_err_nx = r_grant;
                    w_end    = 1'b1;
                end else begin
                    w_data_nx  = w_byte;
                    w_state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (!w_own) begin
                    w_err_nx = r_grant;
                    w_end    = 1'b1;
                end else if (!tx_active) begin
                    w_tx       = 1'b1;
                    w_wdog_nx  = WW'(1);
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                // A drop while a byte is on the wire is deferred to its tx_done.
                w_drop_nx = r_drop | ~w_own;
                if (tx_done) begin
                    if (w_drop_nx) begin
                        w_err_nx = r_grant;
                        w_end    = 1'b1;
                    end else if (r_idx == r_len - 8'd1) begin
                        w_done_nx = r_grant;
                        w_end     = 1'b1;
                    end else begin
                        w_idx_nx   = r_idx + 8'd1;
                        w_state_nx = S_FETCH;
                    end
                end else if (r_wdog >= WW'(TIMEOUT_CYCLES - 1)) begin
                    w_err_nx = r_grant;
                    w_end    = 1'b1;
                end else begin
                    w_wdog_nx = r_wdog + 1'b1;
                end
            end
            S_GUARD: begin
                if (r_gcnt == GW'(GUARD_CYCLES - 1)) w_state_nx = S_IDLE;
                else w_gcnt_nx = r_gcnt + 1'b1;
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_end) begin
            w_state_nx = S_GUARD;
            w_grant_nx = '0;
            w_idx_nx   = 8'd0;
            w_gcnt_nx  = '0;
            w_ptr_nx   = w_nptr;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_win   <= '0;
            r_ptr   <= '0;
            r_len   <= 8'd0;
            r_idx   <= 8'd0;
            r_data  <= 8'd0;
            r_wdog  <= '0;
            r_gcnt  <= '0;
            r_drop  <= 1'b0;
            r_done  <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_win   <= w_win_nx;
            r_ptr   <= w_ptr_nx;
            r_len   <= w_len_nx;
            r_idx   <= w_idx_nx;
            r_data  <= w_data_nx;
            r_wdog  <= w_wdog_nx;
            r_gcnt  <= w_gcnt_nx;
            r_drop  <= w_drop_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
        end
    end

    assign grant       = r_grant;
    assign byte_idx    = r_idx;
    assign done        = r_done;
    assign err         = r_err;
    assign tx_transmit = w_tx;
    assign tx_data     = r_data;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple uart_tx model.
// Expected bytes and done/err events are queued at stimulus time, popped on DUT output.
module tb_uart_tx_arbiter;

    localparam int N     = 2;
    localparam int GUARD = 16;
    localparam int TMO   = 64;

    logic           CLK = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_len;
    logic [N*8-1:0] byte_data;
    logic [N-1:0]   grant, done, err;
    logic [7:0]     byte_idx, tx_data;
    logic           tx_transmit, tx_active, tx_done, busy;

    logic [7:0]  mem0 [256];
    logic [7:0]  mem1 [256];
    logic [15:0] exp_q [$];
    logic [3:0]  evt_q [$];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_strobe = 0, t_strobe = 0, t_txd = 0, t_evt = 0;
    int t_gnt = 0, t_brise = 0, t_bfall = 0, ucnt = 0, s0 = 0;
    bit hang = 1'b0;
    logic [N-1:0] prev_grant = '0;
    logic         prev_busy  = 1'b0;

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .GUARD_CYCLES(GUARD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK),
        .reset_n(reset_n),
        .req(req),
        .req_len(req_len),
        .byte_data(byte_data),
        .grant(grant),
        .byte_idx(byte_idx),
        .done(done),
        .err(err),
        .tx_transmit(tx_transmit),
        .tx_data(tx_data),
        .tx_active(tx_active),
        .tx_done(tx_done),
        .busy(busy)
    );

    always_comb byte_data = {mem1[byte_idx], mem0[byte_idx]};

    always @(posedge CLK) cyc <= cyc + 1;

    // uart_tx model: tx_done 10 cycles after the strobe unless hung.
    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            ucnt      <= 0;
        end else begin
            tx_done <= 1'b0;
            if (tx_transmit) begin
                tx_active <= 1'b1;
                ucnt      <= 1;
            end else if (tx_active) begin
                if (ucnt == 9) begin
                    tx_active <= 1'b0;
                    tx_done   <= !hang;
                end
                ucnt <= ucnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (reset_n) begin
                if (tx_transmit) begin
                    t_strobe = cyc;
                    n_strobe++;
                    if (exp_q.size() == 0) chk("strobe_unexp", 1, 0);
                    else chk("tx_byte", {byte_idx, tx_data}, exp_q.pop_front());
                end
                if (tx_done) t_txd = cyc;
                if ((done | err) != '0) begin
                    t_evt = cyc;
                    if (evt_q.size() == 0) chk("evt_unexp", {done, err}, 0);
                    else chk("evt", {done, err}, evt_q.pop_front());
                    chk("gnt_at_evt", grant, 0);
                end
                if (grant != '0 && prev_grant == '0) t_gnt = cyc;
                if (busy && !prev_busy) t_brise = cyc;
                if (!busy && prev_busy) t_bfall = cyc;
            end
            prev_grant = grant;
            prev_busy  = busy;
        end
    end

    task automatic push_bytes(input int src, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({8'(i), (src == 1) ? mem1[i] : mem0[i]});
    endtask

    task automatic push_evt(input int src, input bit is_err);
        logic [3:0] e;
        e = is_err ? (4'b0001 << src) : (4'b0100 << src);
        evt_q.push_back(e);
    endtask

    task automatic wait_evts(input int n, input int max);
        int got = 0;
        for (int c = 0; c < max && got < n; c++) begin
            @(negedge CLK);
            if ((done | err) != '0) begin
                req = req & ~(done | err);
                got++;
            end
        end
        chk("evt_count", got, n);
        @(negedge CLK);
    endtask

    task automatic wait_idle(input int max);
        int c = 0;
        @(negedge CLK);
        while (busy && c < max) begin
            @(negedge CLK);
            c++;
        end
        chk("idle", {31'd0, busy}, 0);
        @(negedge CLK);
    endtask

    task automatic wait_strobe(input int idx, input int max);
        bit seen = 1'b0;
        for (int c = 0; c < max && !seen; c++) begin
            @(negedge CLK);
            if (tx_transmit && byte_idx == 8'(idx)) seen = 1'b1;
        end
        chk("strobe_seen", {31'd0, seen}, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        req_len = '0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        repeat (3) @(negedge CLK);
        chk("rst_grant", grant, 0);
        chk("rst_idx", byte_idx, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_tx", {tx_transmit, tx_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        reset_n = 1'b1;
        @(negedge CLK);

        // single 3-byte frame
        mem0[0] = 8'hAA; mem0[1] = 8'hBB; mem0[2] = 8'hCC; mem0[3] = 8'hDD;
        mem1[0] = 8'h11; mem1[1] = 8'h22;
        req_len = {8'd0, 8'd3};
        s0 = n_strobe;
        push_bytes(0, 3);
        push_evt(0, 0);
        req = 2'b01;
        wait_evts(1, 300);
        chk("t1_strobes", n_strobe - s0, 3);
        chk("t1_done_lat", t_evt - t_txd, 1);
        wait_idle(100);
        chk("t1_guard", t_bfall - t_evt, GUARD);

        // simultaneous requests after reset, then pointer advance
        do_reset();
        req_len = {8'd2, 8'd2};
        push_bytes(0, 2);
        push_bytes(1, 2);
        push_evt(0, 0);
        push_evt(1, 0);
        req = 2'b11;
        wait_evts(2, 600);
        wait_idle(100);
        req_len = {8'd2, 8'd1};
        push_bytes(0, 1);
        push_evt(0, 0);
        req = 2'b01;
        wait_evts(1, 300);
        wait_idle(100);
        push_bytes(1, 2);
        push_bytes(0, 1);
        push_evt(1, 0);
        push_evt(0, 0);
        req = 2'b11;
        wait_evts(2, 600);
        wait_idle(100);

        // zero-length frame
        req_len = {8'd0, 8'd2};
        s0 = n_strobe;
        push_evt(1, 0);
        req = 2'b10;
        wait_evts(1, 100);
        chk("t3_strobes", n_strobe - s0, 0);
        chk("t3_done_lat", t_evt - t_gnt, 1);
        wait_idle(100);
        chk("t3_busy", t_bfall - t_brise, 1 + GUARD);

        // request dropped during the second byte
        req_len = {8'd2, 8'd4};
        s0 = n_strobe;
        push_bytes(0, 2);
        push_evt(0, 1);
        req = 2'b01;
        wait_strobe(1, 200);
        repeat (3) @(negedge CLK);
        req = 2'b00;
        wait_evts(1, 200);
        chk("t4_err_lat", t_evt - t_txd, 1);
        wait_idle(100);
        chk("t4_strobes", n_strobe - s0, 2);

        // watchdog timeout
        hang = 1'b1;
        req_len = {8'd2, 8'd2};
        s0 = n_strobe;
        push_bytes(0, 1);
        push_evt(0, 1);
        req = 2'b01;
        wait_evts(1, 300);
        chk("t5_err_lat", t_evt - t_strobe, TMO);
        chk("t5_strobes", n_strobe - s0, 1);
        wait_idle(100);
        chk("t5_guard", t_bfall - t_evt, GUARD);
        hang = 1'b0;

        // asynchronous reset in WAIT
        req_len = {8'd2, 8'd3};
        push_bytes(0, 3);
        push_evt(0, 0);
        req = 2'b01;
        wait_strobe(0, 100);
        repeat (4) @(negedge CLK);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_grant", grant, 0);
        chk("t6_idx", byte_idx, 0);
        chk("t6_done_err", {done, err}, 0);
        chk("t6_tx", {tx_transmit, tx_data}, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        exp_q.delete();
        evt_q.delete();
        req = '0;
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        @(negedge CLK);
        req_len = {8'd2, 8'd2};
        push_bytes(0, 2);
        push_evt(0, 0);
        req = 2'b01;
        wait_evts(1, 300);
        wait_idle(100);

        chk("sb_bytes_left", exp_q.size(), 0);
        chk("sb_evts_left", evt_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
